// File: rtl/dq_operand_queue.sv
// DQ-form operand queue: buffers decoded DQ instructions between decode and issue,
// forming the scaled displacement at push time and back-pressuring fetch.
module dq_operand_queue #(
  parameter int DEPTH        = 4,
  parameter int PTR_WIDTH    = 2,
  parameter int STALL_THRESH = 2,
  parameter int opcodeWidth  = 6,
  parameter int regWidth     = 5,
  parameter int immWidth     = 12,
  parameter int addressSize  = 64
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   enable_i,
  input  logic [opcodeWidth-1:0] opcode_i,
  input  logic [regWidth-1:0]    reg1_i,
  input  logic [regWidth-1:0]    reg2_i,
  input  logic                   reg2ValOrZero_i,
  input  logic [immWidth-1:0]    imm_i,
  input  logic                   bit_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [opcodeWidth-1:0] opcode_o,
  output logic [regWidth-1:0]    reg1_o,
  output logic [regWidth-1:0]    reg2_o,
  output logic                   reg2ValOrZero_o,
  output logic                   bit_o,
  output logic [addressSize-1:0] disp_o,
  output logic [PTR_WIDTH:0]     count_o,
  output logic                   stall_o,
  output logic                   overflow_o
);

  typedef struct packed {
    logic [opcodeWidth-1:0] opcode;
    logic [regWidth-1:0]    reg1;
    logic [regWidth-1:0]    reg2;
    logic                   rvz;
    logic                   bt;
    logic [addressSize-1:0] disp;
  } entry_t;

  localparam logic [PTR_WIDTH:0] CntFull = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] CntThr  = (PTR_WIDTH+1)'(STALL_THRESH);

  entry_t                mem_q [DEPTH];
  entry_t                mem_d [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  do_push;
  logic                  sign;
  entry_t                wr_ent;
  entry_t                head;
  logic [PTR_WIDTH:0]    free_cnt;

  assign full    = (count_q == CntFull);
  assign valid_o = (count_q != '0);
  assign push    = enable_i;
  assign pop     = valid_o & ready_i;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push = push & (~full | pop);
  // The DQ field uses big-endian bit naming: its leftmost bit is the sign.
  assign sign    = imm_i[immWidth-1];

  always_comb begin
    wr_ent        = '0;
    wr_ent.opcode = opcode_i;
    wr_ent.reg1   = reg1_i;
    wr_ent.reg2   = reg2_i;
    wr_ent.rvz    = reg2ValOrZero_i;
    wr_ent.bt     = bit_i;
    wr_ent.disp   = {{(addressSize-immWidth-4){sign}}, imm_i, 4'b0000};
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_ent;
        wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end
      unique case ({do_push, pop})
        2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
      if (push && full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: head outputs are gated by valid_o.
  always_ff @(posedge clock_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head            = mem_q[rd_ptr_q];
    opcode_o        = valid_o ? head.opcode : '0;
    reg1_o          = valid_o ? head.reg1   : '0;
    reg2_o          = valid_o ? head.reg2   : '0;
    reg2ValOrZero_o = valid_o & head.rvz;
    bit_o           = valid_o & head.bt;
    disp_o          = valid_o ? head.disp   : '0;
  end

  assign free_cnt   = CntFull - count_q;
  assign stall_o    = (free_cnt <= CntThr);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_dq_operand_queue.sv
// Scoreboard bench for dq_operand_queue: a reference queue tracks pushes,
// pops, drops, flush and reset, and is compared against the DUT each cycle.
module tb_dq_operand_queue;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        rz;
    logic        bt;
    logic [11:0] imm;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, en, rdy;
  logic [5:0]  opcode_i;
  logic [4:0]  reg1_i, reg2_i;
  logic        rz_i, bit_i;
  logic [11:0] imm_i;
  logic        valid_o, rz_o, bit_o, stall_o, ovf_o;
  logic [5:0]  opcode_o;
  logic [4:0]  reg1_o, reg2_o;
  logic [63:0] disp_o;
  logic [2:0]  count_o;

  ent_t exp_q[$];
  logic m_ovf;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dq_operand_queue dut (
    .clock_i(clk), .reset_i(rst), .flush_i(flush), .enable_i(en),
    .opcode_i(opcode_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .reg2ValOrZero_i(rz_i), .imm_i(imm_i), .bit_i(bit_i),
    .ready_i(rdy), .valid_o(valid_o), .opcode_o(opcode_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .reg2ValOrZero_o(rz_o),
    .bit_o(bit_o), .disp_o(disp_o), .count_o(count_o),
    .stall_o(stall_o), .overflow_o(ovf_o)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] disp_of(input logic [11:0] imm);
    logic signed [11:0] s;
    s = imm;
    return 64'(longint'(s) * 16);
  endfunction

  function automatic ent_t mk(input logic [5:0] op, input logic [4:0] r1,
                              input logic [4:0] r2, input logic rz,
                              input logic bt, input logic [11:0] imm);
    ent_t e;
    e = '{op: op, r1: r1, r2: r2, rz: rz, bt: bt, imm: imm};
    return e;
  endfunction

  function automatic ent_t rnd();
    return mk(($urandom % 2) ? 6'd56 : 6'd61, 5'($urandom), 5'($urandom),
              1'($urandom), 1'($urandom), 12'($urandom));
  endfunction

  task automatic check_head();
    check("valid", 64'(valid_o), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("opcode", 64'(opcode_o), 64'(exp_q[0].op));
      check("reg1", 64'(reg1_o), 64'(exp_q[0].r1));
      check("reg2", 64'(reg2_o), 64'(exp_q[0].r2));
      check("rvz", 64'(rz_o), 64'(exp_q[0].rz));
      check("bit", 64'(bit_o), 64'(exp_q[0].bt));
      check("disp", disp_o, disp_of(exp_q[0].imm));
    end
  endtask

  // One clock: drive, check head before the edge, advance the model, check state.
  task automatic cyc(input logic e_en, input ent_t e, input logic e_rdy,
                     input logic e_fl, input logic e_rs);
    logic pop;
    int   sz;
    en = e_en; rdy = e_rdy; flush = e_fl; rst = e_rs;
    opcode_i = e.op; reg1_i = e.r1; reg2_i = e.r2;
    rz_i = e.rz; bit_i = e.bt; imm_i = e.imm;
    #1;
    check_head();
    sz  = exp_q.size();
    pop = (sz != 0) && e_rdy;
    if (e_rs) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else if (e_fl) begin
      exp_q.delete();
    end else if (e_en && sz == 4 && !pop) begin
      m_ovf = 1'b1;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (e_en) exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    check("count", 64'(count_o), 64'(exp_q.size()));
    check("stall", 64'(stall_o), 64'((4 - exp_q.size()) <= 2));
    check("ovf", 64'(ovf_o), 64'(m_ovf));
  endtask

  ent_t z;

  initial begin
    z = '0;
    m_ovf = 1'b0;
    rst = 1'b1; flush = 1'b0; en = 1'b0; rdy = 1'b0;
    opcode_i = '0; reg1_i = '0; reg2_i = '0;
    rz_i = 1'b0; bit_i = 1'b0; imm_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_disp", disp_o, 64'd0);
    rst = 1'b0;

    // 1) basic push, fixed expected fields
    cyc(1, mk(6'd56, 5'd3, 5'd0, 1'b1, 1'b0, 12'h001), 0, 0, 0);
    check("t1_valid", 64'(valid_o), 64'd1);
    check("t1_disp", disp_o, 64'h10);
    check("t1_rvz", 64'(rz_o), 64'd1);
    cyc(0, z, 1, 0, 0);

    // 2) sign extension boundaries
    cyc(1, mk(6'd61, 5'd7, 5'd9, 1'b0, 1'b1, 12'hFFF), 0, 0, 0);
    check("t2_neg", disp_o, 64'hFFFF_FFFF_FFFF_FFF0);
    cyc(1, mk(6'd61, 5'd8, 5'd9, 1'b0, 1'b0, 12'h7FF), 1, 0, 0);
    check("t2_pos", disp_o, 64'h7FF0);
    cyc(0, z, 1, 0, 0);

    // 3) fill to full, then a dropped push
    for (int i = 0; i < 4; i++) cyc(1, rnd(), 0, 0, 0);
    check("t3_full", 64'(count_o), 64'd4);
    cyc(1, rnd(), 0, 0, 0);
    check("t3_ovf", 64'(ovf_o), 64'd1);

    // 4) full with simultaneous push/pop; then drain
    for (int i = 0; i < 6; i++) cyc(1, rnd(), 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, z, 1, 0, 0);

    // 5) streaming with ready held high
    for (int i = 0; i < 3; i++) cyc(1, rnd(), 1, 0, 0);
    cyc(0, z, 1, 0, 0);

    // 6) flush with push, then reset with push
    for (int i = 0; i < 3; i++) cyc(1, rnd(), 0, 0, 0);
    cyc(1, rnd(), 0, 1, 0);
    check("t6_fl_cnt", 64'(count_o), 64'd0);
    check("t6_fl_ovf", 64'(ovf_o), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1, rnd(), 0, 0, 0);
    cyc(1, rnd(), 0, 0, 1);
    check("t6_rs_cnt", 64'(count_o), 64'd0);
    check("t6_rs_ovf", 64'(ovf_o), 64'd0);

    // random traffic, including occasional flush
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 99) < 60), rnd(),
          1'($urandom_range(0, 99) < 50),
          1'($urandom_range(0, 99) < 3), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
